tournament_branch_predictor: RTL and testbench
==============================================

// Module: tournament_branch_predictor
// PURPOSE
//  Consumer end of the decode-side branch_decoded and EX-side branch_result signals. Combines bimodal, gshare and chooser tables.
//  Decode: branch_decoded fields drive lookup; prediction/prediction_gshare/prediction_2bit/recovery_target/ghistory returned same cycle.
//  EX: branch_result trains all three tables and repairs the speculative global history register (GHR) on mispredict.
//  Sits beside the decode stage and is driven by branch_controller; fetch redirect stays in branch_controller.
// PARAMETERS
//  INDEX_WIDTH  10  log2 entries per table; PC index = pc[INDEX_WIDTH+1:2]
//  GHIST_WIDTH  10  GHR bits; must equal INDEX_WIDTH (gshare index = pc_idx ^ ghr)
//  CNT_WIDTH    32  statistics counter width
// PORTS
//  clk                    in   1            core clock
//  rst                    in   1            synchronous, active-high reset
//  i_req_valid            in   1            decode holds a branch/jump (branch_decoded.valid)
//  i_req_accept           in   1            decode advances this cycle (not stalled, not flushed)
//  i_req_is_jump          in   1            unconditional jump
//  i_req_pc               in   ADDR_WIDTH   PC of the branch
//  i_req_target           in   ADDR_WIDTH   decoded target
//  o_prediction           out  1            final BranchOutcome (TAKEN=1)
//  o_prediction_gshare    out  1            gshare component prediction
//  o_prediction_2bit      out  1            bimodal component prediction
//  o_recovery_target      out  ADDR_WIDTH   address to fetch if prediction is wrong
//  o_ghistory             out  GHIST_WIDTH  GHR value used for this lookup
//  i_res_valid            in   1            resolved conditional branch (branch_result.valid)
//  i_res_pc               in   ADDR_WIDTH   PC of resolved branch (new branch_result field)
//  i_res_outcome          in   1            actual outcome
//  i_res_prediction       in   1            final prediction carried down the pipe
//  i_res_prediction_gshare in  1            carried gshare prediction
//  i_res_prediction_2bit  in   1            carried bimodal prediction
//  i_res_ghistory         in   GHIST_WIDTH  carried GHR snapshot
//  o_branch_count         out  CNT_WIDTH    resolved conditional branches
//  o_mispredict_count     out  CNT_WIDTH    resolved mispredictions
// BEHAVIOUR
//  Reset (rst=1 at posedge):
//   - GHR=0; bimodal/gshare counters=2'b01 (weak not-taken); chooser=2'b10 (weak gshare).
//   - Stats counters=0. Outputs are combinational; after reset they reflect these table values.
//  Lookup (combinational, zero latency):
//   - idx=i_req_pc[INDEX_WIDTH+1:2].
//   - p2=bimodal[idx][1]; pg=gshare[idx^GHR][1]; o_prediction = chooser[idx][1] ? pg : p2.
//   - o_ghistory=GHR (pre-shift value).
//   - Jump: o_prediction=TAKEN; o_recovery_target=i_req_target.
//   - Otherwise: o_recovery_target = o_prediction ? i_req_pc+8 (past delay slot) : i_req_target.
//   - i_req_valid=0: outputs are don't-care, but tables read normally (no X).
//  Speculative GHR (posedge):
//   - If i_req_valid & i_req_accept & ~i_req_is_jump: GHR <= {GHR[GHIST_WIDTH-2:0], o_prediction}.
//  Repair (posedge):
//   - mispredict = i_res_valid & (i_res_outcome != i_res_prediction).
//   - On mispredict: GHR <= {i_res_ghistory[GHIST_WIDTH-2:0], i_res_outcome}. Overrides a same-cycle speculative shift.
//  Training (posedge, i_res_valid), with ridx=i_res_pc index:
//   - bimodal[ridx] and gshare[ridx^i_res_ghistory] saturate toward i_res_outcome (max 3, min 0; no wrap).
//   - chooser[ridx]: +1 (sat 3) if gshare right & 2bit wrong; -1 (sat 0) if 2bit right & gshare wrong; else hold.
//   - Stats: o_branch_count +1; o_mispredict_count +1 on mispredict. Both saturate at all-ones.
//  Lookup and update to the same entry in one cycle: lookup returns the OLD value; no bypass.
//  Reset mid-operation: all state returns to reset values next edge; in-flight results are ignored (pipeline is flushed too).
//  Jumps never train tables and never reach i_res_valid.
// STRUCTURE
//  mips_core_pkg:
//   - BranchOutcome enum (reused).
//   - typedef logic [1:0] sat_cnt_t.
//   - Constants CNT_RESET_PHT=2'b01, CNT_RESET_CHOOSER=2'b10.
//  Sub-module branch_counter_table (params INDEX_WIDTH, RESET_VAL):
//   - one async read port; one sync write port that performs the increment/decrement.
//   - Instantiated 3x (bimodal, gshare, chooser).
//  Top holds GHR, recovery-target mux, stats counters.
// TESTING
//  1 Reset, lookup pc=0x100 conditional -> prediction=0, gshare=0, 2bit=0, recovery_target=req_target, ghistory=0.
//  2 Resolve pc=0x100 taken twice, ghist=0 each -> bimodal[0x40]=3; next lookup at GHR=0 predicts TAKEN, recovery=0x108.
//  3 Resolve mispredict with i_res_ghistory=0x155, outcome=1 while a speculative shift fires
//    -> GHR=0x2AB next cycle; mispredict_count=1.
//  4 i_req_valid=1, i_req_accept=0 for 3 cycles -> GHR unchanged; then accept with prediction 1 -> GHR shifts once.
//  5 Train pattern where 2bit wrong/gshare right 2x -> chooser=3 and final prediction follows gshare.
//    Reverse pattern 3x -> chooser=0 and final follows 2bit.
//  6 Same-cycle lookup and update at idx 5 -> lookup sees pre-update counter; jump lookup -> TAKEN, no GHR shift.

Source files
------------

// File: rtl/tournament_branch_predictor_pkg.sv
// Shared types and constants for the tournament branch predictor.
//   branch_outcome_e : resolved/predicted direction (Taken = 1)
//   sat_cnt_t        : 2-bit saturating counter stored in every table
//   sat_step()       : one saturating increment/decrement step
package tournament_branch_predictor_pkg;

  typedef enum logic {
    NotTaken = 1'b0,
    Taken    = 1'b1
  } branch_outcome_e;

  typedef logic [1:0] sat_cnt_t;

  localparam sat_cnt_t CntResetPht     = 2'b01;  // weak not-taken
  localparam sat_cnt_t CntResetChooser = 2'b10;  // weak prefer gshare
  localparam sat_cnt_t CntMax          = 2'b11;
  localparam sat_cnt_t CntMin          = 2'b00;

  function automatic sat_cnt_t sat_step(sat_cnt_t cnt, logic inc);
    sat_cnt_t res;
    if (inc) begin
      res = (cnt == CntMax) ? cnt : sat_cnt_t'(cnt + 2'd1);
    end else begin
      res = (cnt == CntMin) ? cnt : sat_cnt_t'(cnt - 2'd1);
    end
    return res;
  endfunction

endpackage

// File: rtl/tournament_branch_predictor_counter_table.sv
// Table of 2-bit saturating counters.
//   clk_i, rst_i : clock, synchronous active-high reset (all entries -> RESET_VAL)
//   raddr_i      : asynchronous read address; rdata_o returns the stored counter
//   upd_en_i     : step the counter at waddr_i on the next rising edge
//   upd_inc_i    : 1 = saturating increment, 0 = saturating decrement
module tournament_branch_predictor_counter_table
  import tournament_branch_predictor_pkg::*;
#(
  parameter int unsigned INDEX_WIDTH = 10,
  parameter logic [1:0]  RESET_VAL   = CntResetPht
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [INDEX_WIDTH-1:0] raddr_i,
  output logic [1:0]             rdata_o,
  input  logic                   upd_en_i,
  input  logic [INDEX_WIDTH-1:0] waddr_i,
  input  logic                   upd_inc_i
);

  localparam int unsigned Entries = 1 << INDEX_WIDTH;

  sat_cnt_t cnt_q [Entries];

  // No write-to-read bypass: a same-cycle lookup sees the pre-update value.
  assign rdata_o = cnt_q[raddr_i];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < int'(Entries); i++) begin
        cnt_q[i] <= RESET_VAL;
      end
    end else if (upd_en_i) begin
      cnt_q[waddr_i] <= sat_step(cnt_q[waddr_i], upd_inc_i);
    end
  end

endmodule

// File: rtl/tournament_branch_predictor.sv
// Tournament branch predictor: bimodal + gshare components and a per-PC chooser.
//   clk, rst          : clock, synchronous active-high reset
//   i_req_*           : decode-side lookup (combinational, zero latency)
//   o_prediction*     : final / gshare / bimodal predictions for the lookup
//   o_recovery_target : fetch address if the final prediction proves wrong
//   o_ghistory        : GHR value used for this lookup
//   i_res_*           : EX-side resolved conditional branch; trains tables, repairs GHR
//   o_branch_count    : resolved conditional branches (saturating)
//   o_mispredict_count: resolved mispredictions (saturating)
module tournament_branch_predictor
  import tournament_branch_predictor_pkg::*;
#(
  parameter int unsigned INDEX_WIDTH = 10,
  parameter int unsigned GHIST_WIDTH = 10,  // must equal INDEX_WIDTH
  parameter int unsigned CNT_WIDTH   = 32,
  parameter int unsigned ADDR_WIDTH  = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_req_valid,
  input  logic                   i_req_accept,
  input  logic                   i_req_is_jump,
  input  logic [ADDR_WIDTH-1:0]  i_req_pc,
  input  logic [ADDR_WIDTH-1:0]  i_req_target,
  output logic                   o_prediction,
  output logic                   o_prediction_gshare,
  output logic                   o_prediction_2bit,
  output logic [ADDR_WIDTH-1:0]  o_recovery_target,
  output logic [GHIST_WIDTH-1:0] o_ghistory,
  input  logic                   i_res_valid,
  input  logic [ADDR_WIDTH-1:0]  i_res_pc,
  input  logic                   i_res_outcome,
  input  logic                   i_res_prediction,
  input  logic                   i_res_prediction_gshare,
  input  logic                   i_res_prediction_2bit,
  input  logic [GHIST_WIDTH-1:0] i_res_ghistory,
  output logic [CNT_WIDTH-1:0]   o_branch_count,
  output logic [CNT_WIDTH-1:0]   o_mispredict_count
);

  logic [GHIST_WIDTH-1:0] ghr_q, ghr_d;
  logic [CNT_WIDTH-1:0]   branch_cnt_q, branch_cnt_d;
  logic [CNT_WIDTH-1:0]   mispred_cnt_q, mispred_cnt_d;

  logic [INDEX_WIDTH-1:0] req_idx, req_gidx, res_idx, res_gidx;
  logic [1:0]             bim_rdata, gsh_rdata, cho_rdata;
  logic                   pred_cond;
  logic                   mispredict;
  logic                   gsh_right, bim_right;
  logic                   unused_res_pc_bits;

  assign req_idx  = i_req_pc[INDEX_WIDTH+1:2];
  assign req_gidx = req_idx ^ ghr_q;
  assign res_idx  = i_res_pc[INDEX_WIDTH+1:2];
  assign res_gidx = res_idx ^ i_res_ghistory;

  assign unused_res_pc_bits = ^{i_res_pc[ADDR_WIDTH-1:INDEX_WIDTH+2], i_res_pc[1:0]};

  assign mispredict = i_res_valid & (i_res_outcome != i_res_prediction);
  assign gsh_right  = (i_res_prediction_gshare == i_res_outcome);
  assign bim_right  = (i_res_prediction_2bit == i_res_outcome);

  tournament_branch_predictor_counter_table #(
    .INDEX_WIDTH(INDEX_WIDTH),
    .RESET_VAL  (CntResetPht)
  ) u_bimodal (
    .clk_i    (clk),
    .rst_i    (rst),
    .raddr_i  (req_idx),
    .rdata_o  (bim_rdata),
    .upd_en_i (i_res_valid),
    .waddr_i  (res_idx),
    .upd_inc_i(i_res_outcome)
  );

  tournament_branch_predictor_counter_table #(
    .INDEX_WIDTH(INDEX_WIDTH),
    .RESET_VAL  (CntResetPht)
  ) u_gshare (
    .clk_i    (clk),
    .rst_i    (rst),
    .raddr_i  (req_gidx),
    .rdata_o  (gsh_rdata),
    .upd_en_i (i_res_valid),
    .waddr_i  (res_gidx),
    .upd_inc_i(i_res_outcome)
  );

  // Chooser only moves when exactly one component was right; up = trust gshare.
  tournament_branch_predictor_counter_table #(
    .INDEX_WIDTH(INDEX_WIDTH),
    .RESET_VAL  (CntResetChooser)
  ) u_chooser (
    .clk_i    (clk),
    .rst_i    (rst),
    .raddr_i  (req_idx),
    .rdata_o  (cho_rdata),
    .upd_en_i (i_res_valid & (gsh_right ^ bim_right)),
    .waddr_i  (res_idx),
    .upd_inc_i(gsh_right)
  );

  always_comb begin
    o_prediction_2bit   = bim_rdata[1];
    o_prediction_gshare = gsh_rdata[1];
    pred_cond           = cho_rdata[1] ? o_prediction_gshare : o_prediction_2bit;
    o_ghistory          = ghr_q;
    if (i_req_is_jump) begin
      o_prediction      = Taken;
      o_recovery_target = i_req_target;
    end else begin
      o_prediction      = pred_cond;
      // Taken prediction falls back to the instruction after the delay slot.
      o_recovery_target = pred_cond ? (i_req_pc + ADDR_WIDTH'(8)) : i_req_target;
    end
  end

  always_comb begin
    ghr_d = ghr_q;
    // Repair wins over a same-cycle speculative shift.
    if (mispredict) begin
      ghr_d = {i_res_ghistory[GHIST_WIDTH-2:0], i_res_outcome};
    end else if (i_req_valid && i_req_accept && !i_req_is_jump) begin
      ghr_d = {ghr_q[GHIST_WIDTH-2:0], o_prediction};
    end
  end

  always_comb begin
    branch_cnt_d  = branch_cnt_q;
    mispred_cnt_d = mispred_cnt_q;
    if (i_res_valid && !(&branch_cnt_q)) begin
      branch_cnt_d = branch_cnt_q + CNT_WIDTH'(1);
    end
    if (mispredict && !(&mispred_cnt_q)) begin
      mispred_cnt_d = mispred_cnt_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ghr_q         <= '0;
      branch_cnt_q  <= '0;
      mispred_cnt_q <= '0;
    end else begin
      ghr_q         <= ghr_d;
      branch_cnt_q  <= branch_cnt_d;
      mispred_cnt_q <= mispred_cnt_d;
    end
  end

  assign o_branch_count     = branch_cnt_q;
  assign o_mispredict_count = mispred_cnt_q;

endmodule

// File: tb/tb_tournament_branch_predictor.sv
module tb_tournament_branch_predictor;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req_valid, i_req_accept, i_req_is_jump;
  logic [31:0] i_req_pc, i_req_target;
  logic        o_prediction, o_prediction_gshare, o_prediction_2bit;
  logic [31:0] o_recovery_target;
  logic [9:0]  o_ghistory;
  logic        i_res_valid, i_res_outcome, i_res_prediction;
  logic        i_res_prediction_gshare, i_res_prediction_2bit;
  logic [31:0] i_res_pc;
  logic [9:0]  i_res_ghistory;
  logic [31:0] o_branch_count, o_mispredict_count;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  tournament_branch_predictor dut (
    .clk                    (clk),
    .rst                    (rst),
    .i_req_valid            (i_req_valid),
    .i_req_accept           (i_req_accept),
    .i_req_is_jump          (i_req_is_jump),
    .i_req_pc               (i_req_pc),
    .i_req_target           (i_req_target),
    .o_prediction           (o_prediction),
    .o_prediction_gshare    (o_prediction_gshare),
    .o_prediction_2bit      (o_prediction_2bit),
    .o_recovery_target      (o_recovery_target),
    .o_ghistory             (o_ghistory),
    .i_res_valid            (i_res_valid),
    .i_res_pc               (i_res_pc),
    .i_res_outcome          (i_res_outcome),
    .i_res_prediction       (i_res_prediction),
    .i_res_prediction_gshare(i_res_prediction_gshare),
    .i_res_prediction_2bit  (i_res_prediction_2bit),
    .i_res_ghistory         (i_res_ghistory),
    .o_branch_count         (o_branch_count),
    .o_mispredict_count     (o_mispredict_count)
  );

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic v, input logic acc, input logic jmp,
                         input logic [31:0] pc, input logic [31:0] tgt);
    i_req_valid   = v;
    i_req_accept  = acc;
    i_req_is_jump = jmp;
    i_req_pc      = pc;
    i_req_target  = tgt;
  endtask

  task automatic set_res(input logic v, input logic [31:0] pc, input logic outc,
                         input logic pred, input logic pg, input logic p2,
                         input logic [9:0] gh);
    i_res_valid             = v;
    i_res_pc                = pc;
    i_res_outcome           = outc;
    i_res_prediction        = pred;
    i_res_prediction_gshare = pg;
    i_res_prediction_2bit   = p2;
    i_res_ghistory          = gh;
  endtask

  initial begin
    rst = 1'b1;
    set_req(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    set_res(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 10'h0);
    tick();
    tick();
    rst = 1'b0;

    // Reset state and first lookup (idx 0x40).
    set_req(1'b1, 1'b0, 1'b0, 32'h100, 32'h200);
    #1;
    check_eq("rst_pred", 32'(o_prediction), 32'd0);
    check_eq("rst_gshare", 32'(o_prediction_gshare), 32'd0);
    check_eq("rst_2bit", 32'(o_prediction_2bit), 32'd0);
    check_eq("rst_recov", o_recovery_target, 32'h200);
    check_eq("rst_ghist", 32'(o_ghistory), 32'h0);
    check_eq("rst_bcnt", o_branch_count, 32'd0);

    // Train pc 0x100 taken twice at ghist 0 (carried final=1: no mispredict).
    set_res(1'b1, 32'h100, 1'b1, 1'b1, 1'b0, 1'b0, 10'h0);
    tick();
    tick();
    set_res(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 10'h0);
    #1;
    check_eq("trn_2bit", 32'(o_prediction_2bit), 32'd1);
    check_eq("trn_gshare", 32'(o_prediction_gshare), 32'd1);
    check_eq("trn_pred", 32'(o_prediction), 32'd1);
    check_eq("trn_recov", o_recovery_target, 32'h108);
    check_eq("trn_bcnt", o_branch_count, 32'd2);
    check_eq("trn_mcnt", o_mispredict_count, 32'd0);

    // Repair overrides a same-cycle speculative shift.
    set_req(1'b1, 1'b1, 1'b0, 32'h100, 32'h200);
    set_res(1'b1, 32'h300, 1'b1, 1'b0, 1'b0, 1'b0, 10'h155);
    tick();
    set_req(1'b1, 1'b0, 1'b0, 32'h100, 32'h200);
    set_res(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 10'h0);
    #1;
    check_eq("rep_ghist", 32'(o_ghistory), 32'h2AB);
    check_eq("rep_mcnt", o_mispredict_count, 32'd1);
    check_eq("rep_bcnt", o_branch_count, 32'd3);

    // Stalled lookup holds GHR; pc 0xBAC hits trained gshare[0x40] at GHR 0x2AB.
    set_req(1'b1, 1'b0, 1'b0, 32'hBAC, 32'h500);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("stall_ghist", 32'(o_ghistory), 32'h2AB);
    end
    check_eq("stall_pred", 32'(o_prediction), 32'd1);
    check_eq("stall_2bit", 32'(o_prediction_2bit), 32'd0);
    check_eq("stall_recov", o_recovery_target, 32'hBB4);
    i_req_accept = 1'b1;
    tick();
    i_req_accept = 1'b0;
    #1;
    check_eq("acc_ghist", 32'(o_ghistory), 32'h157);

    // Chooser toward gshare 2x (saturates at 3), lookup at idx 8.
    set_req(1'b1, 1'b0, 1'b0, 32'h020, 32'h600);
    set_res(1'b1, 32'h020, 1'b1, 1'b1, 1'b1, 1'b0, 10'h0);
    tick();
    tick();
    set_res(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 10'h0);
    #1;
    check_eq("cho_g_2bit", 32'(o_prediction_2bit), 32'd1);
    check_eq("cho_g_gshare", 32'(o_prediction_gshare), 32'd0);
    check_eq("cho_g_pred", 32'(o_prediction), 32'd0);

    // Chooser toward bimodal 3x -> 0, final follows bimodal.
    set_res(1'b1, 32'h020, 1'b1, 1'b1, 1'b0, 1'b1, 10'h0);
    tick();
    tick();
    tick();
    set_res(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 10'h0);
    #1;
    check_eq("cho_b_pred", 32'(o_prediction), 32'd1);
    check_eq("cho_b_recov", o_recovery_target, 32'h028);
    check_eq("cho_bcnt", o_branch_count, 32'd8);

    // Same-cycle lookup and update at idx 5: old value visible until the edge.
    set_req(1'b1, 1'b0, 1'b0, 32'h014, 32'h700);
    set_res(1'b1, 32'h014, 1'b1, 1'b1, 1'b1, 1'b1, 10'h0);
    #1;
    check_eq("byp_old_2bit", 32'(o_prediction_2bit), 32'd0);
    tick();
    set_res(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 10'h0);
    #1;
    check_eq("byp_new_2bit", 32'(o_prediction_2bit), 32'd1);

    // Jump: TAKEN, recovery to target, no GHR shift.
    set_req(1'b1, 1'b1, 1'b1, 32'h014, 32'h400);
    #1;
    check_eq("jmp_pred", 32'(o_prediction), 32'd1);
    check_eq("jmp_recov", o_recovery_target, 32'h400);
    tick();
    check_eq("jmp_ghist", 32'(o_ghistory), 32'h157);

    // Reset mid-operation with an in-flight result present.
    set_req(1'b1, 1'b0, 1'b0, 32'h100, 32'h200);
    set_res(1'b1, 32'h100, 1'b0, 1'b1, 1'b1, 1'b1, 10'h3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    set_res(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 10'h0);
    #1;
    check_eq("rst2_ghist", 32'(o_ghistory), 32'h0);
    check_eq("rst2_bcnt", o_branch_count, 32'd0);
    check_eq("rst2_mcnt", o_mispredict_count, 32'd0);
    check_eq("rst2_pred", 32'(o_prediction), 32'd0);
    check_eq("rst2_2bit", 32'(o_prediction_2bit), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
